// File: rtl/axil_mil_pkg.sv
// axil_mil_pkg
//   Shared types for the AXI-Lite to register-bus bridge: response codes,
//   the bridge FSM state encoding and the captured register request.
//   The request struct is sized for the largest supported configuration
//   (64-bit address/data). Users take the low bits they need.

package axil_mil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRESP = 2'd2,
        RRESP = 2'd3
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } reg_req_t;

endpackage

// File: rtl/axil_mil_rr_arb.sv
// axil_mil_rr_arb
//   Two-requester round-robin arbiter with a one-hot grant.
//   Requester 0 is the write path and requester 1 is the read path.
//   After reset the pointer favours requester 0. On every taken grant it
//   moves to the requester that was not granted.
// Ports
//   clk, rst  clock and synchronous active-high reset
//   req       request vector, bit 0 = write, bit 1 = read
//   advance   grant is being consumed this cycle
//   gnt       one-hot grant, combinational from req and the pointer

module axil_mil_rr_arb
    import axil_mil_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/axil_mil_reg_bridge.sv
// axil_mil_reg_bridge
//   AXI4-Lite slave that turns each transaction into one outstanding request
//   on a simple register bus. It arbitrates reads against writes, decodes
//   out-of-range addresses and applies a bus timeout.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   aw*/w*/b*/ar*/r*             AXI-Lite slave channels (awprot/arprot unused)
//   reg_req_valid/wr/addr/
//   wdata/wstrb                  register request, held stable while valid
//   reg_ack/reg_err/reg_rdata    completion from the register target
//
// state | meaning
// IDLE  | ready for a grant (except the first cycle after a response)
// REQ   | register request outstanding, timeout counter running
// WRESP | write response held until bready
// RRESP | read response held until rready

module axil_mil_reg_bridge
    import axil_mil_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int REG_AW    = 16,
    parameter int TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [AW-1:0]     awaddr,
    input  logic [2:0]        awprot,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [AW-1:0]     araddr,
    input  logic [2:0]        arprot,
    output logic              rvalid,
    input  logic              rready,
    output logic [DW-1:0]     rdata,
    output logic [1:0]        rresp,
    output logic              reg_req_valid,
    output logic              reg_req_wr,
    output logic [REG_AW-1:0] reg_req_addr,
    output logic [DW-1:0]     reg_req_wdata,
    output logic [DW/8-1:0]   reg_req_wstrb,
    input  logic              reg_ack,
    input  logic              reg_err,
    input  logic [DW-1:0]     reg_rdata
);

    localparam int CW = $clog2(TO_CYCLES + 1);

    state_t          state_q, state_d;
    reg_req_t        req_q, req_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            hold_q, hold_d;
    logic            grant_en;
    logic [1:0]      arb_req;
    logic [1:0]      gnt;
    logic            aw_dec_err, ar_dec_err;
    logic            unused_bits;

    generate
        if (REG_AW < AW) begin : g_decode
            assign aw_dec_err = |awaddr[AW-1:REG_AW];
            assign ar_dec_err = |araddr[AW-1:REG_AW];
        end else begin : g_no_decode
            assign aw_dec_err = 1'b0;
            assign ar_dec_err = 1'b0;
        end
    endgenerate

    // hold_q keeps ready low for the first IDLE cycle after a response.
    // This gives the four-cycle minimum transaction period.
    assign grant_en = (state_q == IDLE) && !hold_q;
    assign arb_req  = grant_en ? {arvalid, awvalid & wvalid} : 2'b00;

    axil_mil_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (grant_en),
        .gnt     (gnt)
    );

    assign awready       = gnt[0];
    assign wready        = gnt[0];
    assign arready       = gnt[1];
    assign bvalid        = (state_q == WRESP);
    assign rvalid        = (state_q == RRESP);
    assign bresp         = bresp_q;
    assign rresp         = rresp_q;
    assign rdata         = rdata_q;
    assign reg_req_valid = (state_q == REQ);
    assign reg_req_wr    = req_q.wr;
    assign reg_req_addr  = req_q.addr[REG_AW-1:0];
    assign reg_req_wdata = req_q.wdata[DW-1:0];
    assign reg_req_wstrb = req_q.wstrb[DW/8-1:0];

    assign unused_bits = ^{awprot, arprot, req_q.addr, req_q.wdata, req_q.wstrb};

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        bresp_d = bresp_q;
        rresp_d = rresp_q;
        rdata_d = rdata_q;
        hold_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt[0]) begin
                    req_d.wr    = 1'b1;
                    req_d.addr  = 64'(awaddr[REG_AW-1:0]);
                    req_d.wdata = 64'(wdata);
                    req_d.wstrb = 8'(wstrb);
                    if (aw_dec_err) begin
                        bresp_d = RESP_DECERR;
                        state_d = WRESP;
                    end else begin
                        state_d = REQ;
                    end
                end else if (gnt[1]) begin
                    req_d.wr    = 1'b0;
                    req_d.addr  = 64'(araddr[REG_AW-1:0]);
                    req_d.wdata = '0;
                    req_d.wstrb = '0;
                    if (ar_dec_err) begin
                        rresp_d = RESP_DECERR;
                        rdata_d = '0;
                        state_d = RRESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // An ack on the terminal count still wins over the timeout.
                if (reg_ack) begin
                    if (req_q.wr) begin
                        bresp_d = reg_err ? RESP_SLVERR : RESP_OKAY;
                        state_d = WRESP;
                    end else begin
                        rresp_d = reg_err ? RESP_SLVERR : RESP_OKAY;
                        rdata_d = reg_err ? '0 : reg_rdata;
                        state_d = RRESP;
                    end
                end else if (cnt_q == CW'(TO_CYCLES - 1)) begin
                    if (req_q.wr) begin
                        bresp_d = RESP_SLVERR;
                        state_d = WRESP;
                    end else begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = '0;
                        state_d = RRESP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRESP: begin
                if (bready) begin
                    state_d = IDLE;
                    hold_d  = 1'b1;
                end
            end
            RRESP: begin
                if (rready) begin
                    state_d = IDLE;
                    hold_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_axil_mil_reg_bridge.sv
// tb_axil_mil_reg_bridge
//   Directed bench for axil_mil_reg_bridge (AW=32, DW=32, REG_AW=16,
//   TO_CYCLES=4). Inputs change 1 time unit after the rising edge.
//   Outputs are sampled on the falling edge.

module tb_axil_mil_reg_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int REG_AW = 16;
    localparam int TO_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [AW-1:0]     awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic [DW-1:0]     wdata, rdata, reg_req_wdata, reg_rdata;
    logic [DW/8-1:0]   wstrb, reg_req_wstrb;
    logic [1:0]        bresp, rresp;
    logic              reg_req_valid, reg_req_wr, reg_ack, reg_err;
    logic [REG_AW-1:0] reg_req_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_mil_reg_bridge #(
        .AW(AW), .DW(DW), .REG_AW(REG_AW), .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_req_valid(reg_req_valid), .reg_req_wr(reg_req_wr),
        .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata),
        .reg_req_wstrb(reg_req_wstrb),
        .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Returns one unit after the handshake edge, i.e. in cycle N+1.
    task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        next_cycle();
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        sample();
        while (!(awready && wready) && n < 20) begin
            next_cycle();
            sample();
            n++;
        end
        checks++;
        if (!(awready && wready)) begin
            errors++;
            $display("FAIL write_grant: awready=%b wready=%b, expected 1/1", awready, wready);
        end
        next_cycle();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic start_read(input logic [31:0] a);
        int n = 0;
        next_cycle();
        araddr = a; arvalid = 1'b1;
        sample();
        while (!arready && n < 20) begin
            next_cycle();
            sample();
            n++;
        end
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL read_grant: arready=%b, expected 1", arready);
        end
        next_cycle();
        arvalid = 1'b0;
    endtask

    task automatic run_read(input logic [31:0] a, input logic [31:0] ack_data, input logic err,
                            input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
        logic [15:0] exp_addr;
        exp_addr = a[15:0];
        start_read(a);
        reg_ack = 1'b1; reg_err = err; reg_rdata = ack_data;
        sample();
        checks++;
        if ({reg_req_valid, reg_req_wr, reg_req_addr} !== {1'b1, 1'b0, exp_addr}) begin
            errors++;
            $display("FAIL read_req: valid/wr/addr=%b/%b/%h, expected 1/0/%h",
                     reg_req_valid, reg_req_wr, reg_req_addr, exp_addr);
        end
        next_cycle();
        reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0; rready = 1'b1;
        sample();
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, exp_resp, exp_rdata}) begin
            errors++;
            $display("FAIL read_resp: rvalid/rresp/rdata=%b/%b/%h, expected 1/%b/%h",
                     rvalid, rresp, rdata, exp_resp, exp_rdata);
        end
        next_cycle();
        rready = 1'b0;
        sample();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_done: rvalid=%b, expected 0", rvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        sample();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, reg_req_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {awready, wready, arready, bvalid, rvalid, reg_req_valid});
        end
        checks++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h, expected 0", bresp, rresp, rdata);
        end
        checks++;
        if ({reg_req_wr, reg_req_addr, reg_req_wdata, reg_req_wstrb} !== 53'h0) begin
            errors++;
            $display("FAIL reset_req: wr=%b addr=%h wdata=%h wstrb=%h, expected 0",
                     reg_req_wr, reg_req_addr, reg_req_wdata, reg_req_wstrb);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_write();
        start_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        reg_ack = 1'b1; reg_err = 1'b0;
        sample();
        checks++;
        if ({reg_req_valid, reg_req_wr, reg_req_addr, reg_req_wdata, reg_req_wstrb} !==
            {1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF}) begin
            errors++;
            $display("FAIL write_req: valid=%b wr=%b addr=%h wdata=%h wstrb=%h, expected 1 1 0010 deadbeef f",
                     reg_req_valid, reg_req_wr, reg_req_addr, reg_req_wdata, reg_req_wstrb);
        end
        checks++;
        if ({bvalid, awready} !== 2'b00) begin
            errors++;
            $display("FAIL write_n1: bvalid=%b awready=%b, expected 0/0", bvalid, awready);
        end
        next_cycle();
        reg_ack = 1'b0; bready = 1'b1;
        sample();
        checks++;
        if ({bvalid, bresp, reg_req_valid} !== {1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL write_resp: bvalid=%b bresp=%b reg_req_valid=%b, expected 1/00/0",
                     bvalid, bresp, reg_req_valid);
        end
        next_cycle();
        bready = 1'b0;
        sample();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_done: bvalid=%b, expected 0", bvalid);
        end
    endtask

    task automatic test_read();
        run_read(32'h0000_0020, 32'h1234_5678, 1'b0, 2'b00, 32'h1234_5678);
        run_read(32'h0000_0020, 32'h1234_5678, 1'b1, 2'b10, 32'h0000_0000);
    endtask

    task automatic test_ack_at_limit();
        start_write(32'h0000_0108, 32'h1111_2222, 4'h0);
        sample();
        checks++;
        if ({reg_req_valid, reg_req_wstrb} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL zero_strb: valid=%b wstrb=%h, expected 1/0", reg_req_valid, reg_req_wstrb);
        end
        next_cycle();
        next_cycle();
        next_cycle();
        reg_ack = 1'b1; reg_err = 1'b0;
        sample();
        checks++;
        if (reg_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL limit_valid: reg_req_valid=%b, expected 1", reg_req_valid);
        end
        next_cycle();
        reg_ack = 1'b0; bready = 1'b1;
        sample();
        checks++;
        if ({bvalid, bresp} !== {1'b1, 2'b00}) begin
            errors++;
            $display("FAIL limit_ack_wins: bvalid=%b bresp=%b, expected 1/00", bvalid, bresp);
        end
        next_cycle();
        bready = 1'b0;
    endtask

    task automatic test_timeout();
        int hi = 0;
        int n = 0;
        start_write(32'h0000_0100, 32'h0BAD_F00D, 4'h3);
        bready = 1'b1;
        sample();
        while (!bvalid && n < 20) begin
            if (reg_req_valid) hi++;
            next_cycle();
            sample();
            n++;
        end
        checks++;
        if (hi !== TO_CYCLES) begin
            errors++;
            $display("FAIL timeout_valid_len: reg_req_valid high %0d cycles, expected %0d", hi, TO_CYCLES);
        end
        checks++;
        if (n !== TO_CYCLES) begin
            errors++;
            $display("FAIL timeout_latency: bvalid after %0d cycles, expected %0d", n + 1, TO_CYCLES + 1);
        end
        checks++;
        if ({bvalid, bresp} !== {1'b1, 2'b10}) begin
            errors++;
            $display("FAIL timeout_resp: bvalid=%b bresp=%b, expected 1/10", bvalid, bresp);
        end
        next_cycle();
        bready = 1'b0;
        next_cycle();
        reg_ack = 1'b1; reg_err = 1'b1; reg_rdata = 32'hFFFF_FFFF;
        sample();
        next_cycle();
        reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
        sample();
        checks++;
        if ({bvalid, rvalid, reg_req_valid} !== 3'b000) begin
            errors++;
            $display("FAIL late_ack: bvalid/rvalid/reg_req_valid=%b%b%b, expected 000",
                     bvalid, rvalid, reg_req_valid);
        end
        run_read(32'h0000_0104, 32'h0000_0A5A, 1'b0, 2'b00, 32'h0000_0A5A);
    endtask

    task automatic test_decerr();
        logic saw_req = 1'b0;
        start_read(32'h0001_0000);
        sample();
        if (reg_req_valid) saw_req = 1'b1;
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, 2'b11, 32'h0}) begin
            errors++;
            $display("FAIL decerr_read: rvalid=%b rresp=%b rdata=%h, expected 1/11/0", rvalid, rresp, rdata);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            if (reg_req_valid) saw_req = 1'b1;
        end
        next_cycle();
        rready = 1'b1;
        sample();
        next_cycle();
        rready = 1'b0;
        sample();
        if (reg_req_valid) saw_req = 1'b1;
        checks++;
        if ({saw_req, rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL decerr_noreq: saw_req=%b rvalid=%b, expected 0/0", saw_req, rvalid);
        end
        start_write(32'h8000_0004, 32'h5555_5555, 4'hF);
        sample();
        checks++;
        if ({bvalid, bresp, reg_req_valid} !== {1'b1, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL decerr_write: bvalid=%b bresp=%b reg_req_valid=%b, expected 1/11/0",
                     bvalid, bresp, reg_req_valid);
        end
        next_cycle();
        bready = 1'b1;
        next_cycle();
        bready = 1'b0;
    endtask

    task automatic test_backpressure();
        start_read(32'h0000_0030);
        reg_ack = 1'b1; reg_rdata = 32'hCAFE_F00D;
        sample();
        next_cycle();
        reg_ack = 1'b0; reg_rdata = '0;
        awaddr = 32'h0000_0034; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++;
            if ({rvalid, rresp, rdata, awready} !== {1'b1, 2'b00, 32'hCAFE_F00D, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_%0d: rvalid=%b rresp=%b rdata=%h awready=%b, expected 1/00/cafef00d/0",
                         i, rvalid, rresp, rdata, awready);
            end
            next_cycle();
        end
        awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1;
        next_cycle();
        rready = 1'b0;
        sample();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: rvalid=%b, expected 0", rvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq = '0;
        int ng = 0;
        int cyc = 0;
        int last_cyc = 0;
        logic both = 1'b0;
        logic spacing_ok = 1'b1;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        awaddr = 32'h0000_0040; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; araddr = 32'h0000_0044;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        reg_ack = 1'b1; reg_err = 1'b0; reg_rdata = 32'h5555_AAAA;
        bready = 1'b1; rready = 1'b1;
        while (ng < 8 && cyc < 100) begin
            sample();
            if (awready && arready) both = 1'b1;
            if (awready || arready) begin
                if (ng > 0 && (cyc - last_cyc) != 4) spacing_ok = 1'b0;
                seq[ng] = arready;
                last_cyc = cyc;
                ng++;
            end
            next_cycle();
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (4) next_cycle();
        reg_ack = 1'b0; reg_rdata = '0; bready = 1'b0; rready = 1'b0;
        checks++;
        if (ng !== 8) begin
            errors++;
            $display("FAIL arb_count: %0d grants, expected 8", ng);
        end
        checks++;
        if (seq !== 8'b1010_1010) begin
            errors++;
            $display("FAIL arb_order: seq=%b (bit i=1 read), expected 10101010", seq);
        end
        checks++;
        if (both !== 1'b0) begin
            errors++;
            $display("FAIL arb_onehot: both readies seen=%b, expected 0", both);
        end
        checks++;
        if (spacing_ok !== 1'b1) begin
            errors++;
            $display("FAIL arb_spacing: spacing_ok=%b, expected 1 (4 cycles per grant)", spacing_ok);
        end
    endtask

    task automatic test_reset_mid();
        logic saw = 1'b0;
        start_write(32'h0000_0200, 32'h7777_8888, 4'hC);
        rst = 1'b1;
        sample();
        checks++;
        if (reg_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req: reg_req_valid=%b, expected 1", reg_req_valid);
        end
        next_cycle();
        rst = 1'b0; bready = 1'b1; reg_ack = 1'b1;
        sample();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, reg_req_valid, bresp, rresp, rdata,
             reg_req_wr, reg_req_addr, reg_req_wdata, reg_req_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: bvalid=%b reg_req_valid=%b addr=%h wdata=%h, expected all 0",
                     bvalid, reg_req_valid, reg_req_addr, reg_req_wdata);
        end
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            sample();
            if (bvalid || rvalid || reg_req_valid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_noresp: activity=%b, expected 0", saw);
        end
        reg_ack = 1'b0; bready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b010;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arprot = 3'b101;
        rready = 1'b0;
        reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
        test_reset();
        test_write();
        test_read();
        test_ack_at_limit();
        test_timeout();
        test_decerr();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
